bist_sequencer: RTL and testbench

Central BIST controller for the scan-wrapped CUT. It sequences the LFSR pattern generator, the CUT input mux, the scan enable and the MISR compactor through a fixed shift/capture schedule. It then compares the final MISR signature against a golden value and reports pass/fail. It sits between the top-level BIST start/end pins and the TPG/CUT/MISR datapath, and replaces the ad-hoc mux select and the signature comparison at top level.

---
 rtl/bist_sequencer.sv | 92 +++++++++
 tb/tb_bist_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/bist_sequencer.sv
// bist_sequencer: BIST controller sequencing TPG, CUT scan and MISR, then comparing the signature to GOLDEN_SIG.
// Optional `BIST_ABORT_EN adds a bist_abort input that jumps straight to DONE with a fail result.
module bist_sequencer #(
    parameter int N_PATTERNS = 4,
    parameter int SCAN_LEN = 3,
    parameter int SIG_W = 3,
    parameter logic [SIG_W-1:0] GOLDEN_SIG = 3'b101
) (
    input  logic CLK,
    input  logic RST,
    input  logic bist_start,
`ifdef BIST_ABORT_EN
    input  logic bist_abort,
`endif
    input  logic [SIG_W-1:0] misr_sig,
    output logic tpg_clr,
    output logic misr_clr,
    output logic tpg_step,
    output logic tpg_sel,
    output logic scan_en,
    output logic misr_en,
    output logic running,
    output logic bist_end,
    output logic pass_fail,
    output logic [$clog2(N_PATTERNS+1)-1:0] pat_idx
);
    localparam int PW = $clog2(N_PATTERNS+1);
    localparam int CW = $clog2(SCAN_LEN+1);

    typedef enum logic [2:0] {IDLE, INIT, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE} state_t;

    state_t st, nxt;
    logic [CW-1:0] cnt;
    logic ab;
    logic last_shift;

`ifdef BIST_ABORT_EN
    assign ab = bist_abort && (st inside {INIT, SHIFT, CAPTURE, UNLOAD, COMPARE});
`else
    assign ab = 1'b0;
`endif
    assign last_shift = cnt == CW'(SCAN_LEN-1);

    always_comb begin
        nxt = st;
        case (st)
            IDLE:    nxt = bist_start ? INIT : IDLE;
            INIT:    nxt = SHIFT;
            SHIFT:   nxt = last_shift ? CAPTURE : SHIFT;
            CAPTURE: nxt = (pat_idx == PW'(N_PATTERNS-1)) ? UNLOAD : SHIFT;
            UNLOAD:  nxt = last_shift ? COMPARE : UNLOAD;
            COMPARE: nxt = DONE;
            DONE:    nxt = bist_start ? DONE : IDLE;
            default: nxt = IDLE;
        endcase
        if (ab)
            nxt = DONE;
    end

    // Outputs are decoded from the next state so every output is a flop that lines up with st.
    always_ff @(posedge CLK) begin
        if (RST) begin
            st        <= IDLE;
            cnt       <= '0;
            pat_idx   <= '0;
            pass_fail <= 1'b0;
            tpg_clr   <= 1'b0;
            misr_clr  <= 1'b0;
            tpg_step  <= 1'b0;
            tpg_sel   <= 1'b0;
            scan_en   <= 1'b0;
            misr_en   <= 1'b0;
            running   <= 1'b0;
            bist_end  <= 1'b0;
        end else begin
            st        <= nxt;
            cnt       <= (st == nxt && (st == SHIFT || st == UNLOAD)) ? cnt + 1'b1 : '0;
            pat_idx   <= (nxt == INIT || nxt == IDLE) ? '0 :
                         (st == CAPTURE && pat_idx != PW'(N_PATTERNS)) ? pat_idx + 1'b1 : pat_idx;
            pass_fail <= (st == COMPARE && !ab) ? (misr_sig == GOLDEN_SIG) :
                         (st == DONE && nxt == DONE) ? pass_fail : 1'b0;
            tpg_clr   <= nxt == INIT;
            misr_clr  <= nxt == INIT;
            tpg_step  <= nxt == CAPTURE;
            tpg_sel   <= nxt inside {INIT, SHIFT, CAPTURE, UNLOAD, COMPARE};
            running   <= nxt inside {INIT, SHIFT, CAPTURE, UNLOAD, COMPARE};
            scan_en   <= nxt inside {SHIFT, UNLOAD};
            misr_en   <= nxt inside {SHIFT, CAPTURE, UNLOAD};
            bist_end  <= nxt == DONE;
        end
    end
endmodule

// File: tb/tb_bist_sequencer.sv
// tb_bist_sequencer: randomized self-checking bench comparing bist_sequencer against a cycle-index schedule model.
module tb_bist_sequencer;
    localparam int N = 4;
    localparam int S = 3;
    localparam int RUN = 1 + N*(S+1) + S + 1;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic bist_start = 1'b0;
    logic bist_abort = 1'b0;
    logic [2:0] misr_sig = 3'b000;
    logic tpg_clr, misr_clr, tpg_step, tpg_sel, scan_en, misr_en, running, bist_end, pass_fail;
    logic [2:0] pat_idx;

    int checks = 0;
    int fails = 0;

    bist_sequencer dut (
        .CLK(CLK),
        .RST(RST),
        .bist_start(bist_start),
`ifdef BIST_ABORT_EN
        .bist_abort(bist_abort),
`endif
        .misr_sig(misr_sig),
        .tpg_clr(tpg_clr),
        .misr_clr(misr_clr),
        .tpg_step(tpg_step),
        .tpg_sel(tpg_sel),
        .scan_en(scan_en),
        .misr_en(misr_en),
        .running(running),
        .bist_end(bist_end),
        .pass_fail(pass_fail),
        .pat_idx(pat_idx)
    );

    always #5 CLK = ~CLK;

    // Expected {tpg_clr,misr_clr,tpg_step,tpg_sel,scan_en,misr_en,running} for run cycle k (k=0 is INIT).
    function automatic logic [6:0] exp_ctl(int k);
        int body = N*(S+1);
        if (k == 0) return 7'b1101001;
        if (k <= body) return ((k-1) % (S+1) < S) ? 7'b0001111 : 7'b0011011;
        if (k <= body + S) return 7'b0001111;
        return 7'b0001001;
    endfunction

    function automatic int exp_pat(int k);
        int c;
        if (k == 0) return 0;
        c = (k-1) / (S+1);
        return (c > N) ? N : c;
    endfunction

    function automatic logic [8:0] outs();
        return {tpg_clr, misr_clr, tpg_step, tpg_sel, scan_en, misr_en, running, bist_end, pass_fail};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bist_start = 1'b1;
        tick();
        checks++;
        if (outs() !== 9'd0 || pat_idx !== 3'd0) begin
            fails++;
            $display("FAIL reset: outs=%b pat=%0d required outs=0 pat=0", outs(), pat_idx);
        end
        RST = 1'b0;
        bist_start = 1'b0;
        tick();
    endtask

    // Full run; returns early after the reset edge when rst_at >= 0.
    task automatic test_run(input logic [2:0] sig, input bit toggle, input int rst_at);
        int n_scan = 0, n_step = 0, n_clr = 0, n_bad = 0;
        bit pass_exp = (sig == 3'b101);
        bist_start = 1'b1;
        tick();
        for (int k = 0; k < RUN; k++) begin
            if ({outs(), pat_idx} !== {exp_ctl(k), 2'b00, 3'(exp_pat(k))}) begin
                n_bad++;
                if (n_bad < 4)
                    $display("FAIL sched k=%0d: outs=%b pat=%0d required outs=%b00 pat=%0d",
                             k, outs(), pat_idx, exp_ctl(k), exp_pat(k));
            end
            n_scan += scan_en;
            n_step += tpg_step;
            n_clr  += tpg_clr + misr_clr;
            if (tpg_step && scan_en) n_bad++;
            if (k == rst_at) begin
                RST = 1'b1;
                tick();
                RST = 1'b0;
                checks++;
                if (outs() !== 9'd0 || pat_idx !== 3'd0) begin
                    fails++;
                    $display("FAIL mid_reset: outs=%b pat=%0d required outs=0 pat=0", outs(), pat_idx);
                end
                return;
            end
            bist_start = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
            misr_sig = (k == RUN-1) ? sig : 3'($urandom);
            tick();
        end
        checks++;
        if (n_bad != 0) begin
            fails++;
            $display("FAIL sched: %0d bad cycles, required 0", n_bad);
        end
        checks++;
        if (n_scan != N*S + S || n_step != N || n_clr != 2) begin
            fails++;
            $display("FAIL counts: scan=%0d step=%0d clr=%0d required %0d %0d 2", n_scan, n_step, n_clr, N*S+S, N);
        end
        checks++;
        if ({bist_end, pass_fail, running, tpg_sel, pat_idx} !== {1'b1, pass_exp, 2'b00, 3'(N)}) begin
            fails++;
            $display("FAIL done sig=%b: end=%b pf=%b run=%b sel=%b pat=%0d required 1 %b 0 0 %0d",
                     sig, bist_end, pass_fail, running, tpg_sel, pat_idx, pass_exp, N);
        end
        bist_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bist_end, pass_fail, running, pat_idx} !== {1'b1, pass_exp, 1'b0, 3'(N)}) begin
                fails++;
                $display("FAIL hold: end=%b pf=%b run=%b pat=%0d required 1 %b 0 %0d",
                         bist_end, pass_fail, running, pat_idx, pass_exp, N);
            end
        end
        bist_start = 1'b0;
        tick();
        checks++;
        if (outs() !== 9'd0 || pat_idx !== 3'd0) begin
            fails++;
            $display("FAIL release: outs=%b pat=%0d required outs=0 pat=0", outs(), pat_idx);
        end
    endtask

    task automatic test_abort();
        bist_start = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            misr_sig = 3'b101;
            tick();
        end
        bist_abort = 1'b1;
        tick();
        bist_abort = 1'b0;
        checks++;
        if ({bist_end, pass_fail, running, scan_en} !== 4'b1000) begin
            fails++;
            $display("FAIL abort: end=%b pf=%b run=%b scan=%b required 1 0 0 0", bist_end, pass_fail, running, scan_en);
        end
        bist_start = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_run(3'b101, 1'b0, -1);
        test_run(3'b100, 1'b0, -1);
        test_run(3'b101, 1'b1, -1);
        test_run(3'b101, 1'b0, 1 + (S+1) + S);
        test_run(3'b101, 1'b0, -1);
        for (int i = 0; i < 4; i++)
            test_run(3'($urandom), 1'($urandom_range(0, 1)), -1);
`ifdef BIST_ABORT_EN
        test_abort();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
